// File: rtl/qam_mapper_controller.sv
// Buffers a frame of 4-bit 16-QAM symbol words, then replays it one symbol per
// SYM_DIV clocks as Gray-mapped signed I/Q levels.
//   state | meaning
//   IDLE  | disabled, buffer empty, outputs at reset values
//   LOAD  | host writes words into the buffer, waits for start
//   SEND  | replaying buffered words, one every SYM_DIV clocks
//   DONE  | frame finished; next write begins a new frame
module qam_mapper_controller #(
  parameter int DEPTH   = 16,
  parameter int SYM_DIV = 4,
  localparam int LW     = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(DEPTH),
  localparam int DW     = $clog2(SYM_DIV)
) (
  input  logic          dclk,
  input  logic          reset,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [3:0]    wr_data,
  input  logic          start,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          overrun,
  output logic          busy,
  output logic          complete,
  output logic          sym_valid,
  output logic [2:0]    sym_i,
  output logic [2:0]    sym_q
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    SEND = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] div;
  logic          div_tc;
  logic          last_sym;
  logic          wr_accept;
  logic [3:0]    rd_word;

  function automatic logic [2:0] gray_lvl(input logic [1:0] b);
    logic [2:0] v;
    case (b)
      2'b00:   v = 3'b101;
      2'b01:   v = 3'b111;
      2'b11:   v = 3'b001;
      default: v = 3'b011;
    endcase
    return v;
  endfunction

  assign full      = (level == LW'(DEPTH));
  assign busy      = (state == SEND);
  assign complete  = (state == DONE);
  assign div_tc    = (div == DW'(SYM_DIV - 1));
  assign last_sym  = (LW'(rd_ptr) == level - LW'(1));
  assign wr_accept = wr_en && !full;
  assign rd_word   = mem[rd_ptr];

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (enable) state_nx = LOAD;
      // a same-cycle write makes an empty buffer non-empty, so start is honoured
      LOAD: if (start && (level != '0 || wr_en)) state_nx = SEND;
      SEND: if (div_tc && last_sym) state_nx = DONE;
      DONE: if (wr_en) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
  end

  always_ff @(posedge dclk) begin
    if (enable) begin
      if (state == LOAD && wr_accept)   mem[level[PW-1:0]] <= wr_data;
      else if (state == DONE && wr_en)  mem[0] <= wr_data;
    end
  end

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      level     <= '0;
      overrun   <= 1'b0;
      sym_valid <= 1'b0;
      sym_i     <= 3'b000;
      sym_q     <= 3'b000;
      rd_ptr    <= '0;
      div       <= '0;
    end else if (!enable) begin
      level     <= '0;
      overrun   <= 1'b0;
      sym_valid <= 1'b0;
      sym_i     <= 3'b000;
      sym_q     <= 3'b000;
      rd_ptr    <= '0;
      div       <= '0;
    end else begin
      sym_valid <= 1'b0;
      case (state)
        IDLE: begin
          level   <= '0;
          overrun <= 1'b0;
          sym_i   <= 3'b000;
          sym_q   <= 3'b000;
          rd_ptr  <= '0;
          div     <= '0;
        end
        LOAD: begin
          if (wr_en) begin
            if (!full) level   <= level + LW'(1);
            else       overrun <= 1'b1;
          end
          rd_ptr <= '0;
          div    <= '0;
        end
        SEND: begin
          if (wr_en) overrun <= 1'b1;
          if (div_tc) begin
            div       <= '0;
            sym_i     <= gray_lvl(rd_word[3:2]);
            sym_q     <= gray_lvl(rd_word[1:0]);
            sym_valid <= 1'b1;
            if (last_sym) begin
              rd_ptr <= '0;
              level  <= '0;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        DONE: begin
          rd_ptr <= '0;
          div    <= '0;
          level  <= wr_en ? LW'(1) : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qam_mapper_controller.sv
// Directed bench for qam_mapper_controller with hand-computed expectations.
module tb_qam_mapper_controller;
  localparam int DEPTH   = 16;
  localparam int SYM_DIV = 4;
  localparam logic [2:0] LN3 = 3'b101, LN1 = 3'b111, LP1 = 3'b001, LP3 = 3'b011;

  logic       dclk = 1'b0;
  logic       reset;
  logic       enable, wr_en, start;
  logic [3:0] wr_data;
  logic [4:0] level;
  logic       full, overrun, busy, complete, sym_valid;
  logic [2:0] sym_i, sym_q;

  int checks   = 0;
  int failures = 0;
  int strobes;
  logic [2:0] last_i, last_q;

  qam_mapper_controller #(.DEPTH(DEPTH), .SYM_DIV(SYM_DIV)) dut (
    .dclk(dclk), .reset(reset), .enable(enable), .wr_en(wr_en),
    .wr_data(wr_data), .start(start), .level(level), .full(full),
    .overrun(overrun), .busy(busy), .complete(complete),
    .sym_valid(sym_valid), .sym_i(sym_i), .sym_q(sym_q)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_count(input int n);
    strobes = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (sym_valid) begin
        strobes++;
        last_i = sym_i;
        last_q = sym_q;
      end
    end
  endtask

  task automatic to_load();
    enable = 1'b0; tick();
    enable = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; wr_en = 1'b0; start = 1'b0; wr_data = 4'h0;
    for (int k = 0; k < 6; k++) begin
      enable = 1'($urandom); wr_en = 1'($urandom); start = 1'($urandom);
      wr_data = 4'($urandom);
      tick();
    end
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_complete", complete, 0);
    chk("rst_valid", sym_valid, 0);
    chk("rst_sym_i", sym_i, 0);
    chk("rst_sym_q", sym_q, 0);

    enable = 1'b0; wr_en = 1'b0; start = 1'b0;
    #2 reset = 1'b1;
    tick();
    wr_en = 1'b1; start = 1'b1; tick(); tick();
    wr_en = 1'b0; start = 1'b0;
    chk("dis_level", level, 0);
    chk("dis_busy", busy, 0);

    // basic three-symbol frame
    enable = 1'b1; tick();
    write_word(4'h0); write_word(4'h5); write_word(4'hF);
    chk("f3_level", level, 3);
    start = 1'b1; tick(); start = 1'b0;
    chk("f3_busy", busy, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("f3_valid", sym_valid, (k % 4 == 0) ? 1 : 0);
      if (k == 4)  begin chk("f3_i0", sym_i, LN3); chk("f3_q0", sym_q, LN3); end
      if (k == 8)  begin chk("f3_i1", sym_i, LN1); chk("f3_q1", sym_q, LN1); end
      if (k == 12) begin
        chk("f3_i2", sym_i, LP1); chk("f3_q2", sym_q, LP1);
        chk("f3_complete", complete, 1); chk("f3_busy_end", busy, 0);
      end
    end
    tick();
    chk("f3_valid_after", sym_valid, 0);
    chk("f3_hold_i", sym_i, LP1);
    chk("f3_done_start_ign", complete, 1);

    // fill past capacity
    to_load();
    chk("ful_ovr_clr", overrun, 0);
    for (int k = 0; k < 16; k++) write_word(4'(k));
    chk("ful_level", level, 16);
    chk("ful_full", full, 1);
    chk("ful_ovr_pre", overrun, 0);
    write_word(4'h9);
    chk("ful_ovr", overrun, 1);
    chk("ful_level2", level, 16);
    start = 1'b1; tick(); start = 1'b0;
    run_count(16 * SYM_DIV + 8);
    chk("ful_strobes", strobes, 16);
    chk("ful_last_i", last_i, LP1);
    chk("ful_last_q", last_q, LP1);
    chk("ful_complete", complete, 1);
    chk("ful_ovr_held", overrun, 1);

    // start on empty buffer, then write+start in one cycle
    to_load();
    start = 1'b1; tick(); start = 1'b0;
    chk("emp_busy", busy, 0);
    chk("emp_level", level, 0);
    wr_en = 1'b1; wr_data = 4'hA; start = 1'b1; tick();
    wr_en = 1'b0; start = 1'b0;
    chk("ws_busy", busy, 1);
    chk("ws_level", level, 1);
    run_count(8);
    chk("ws_strobes", strobes, 1);
    chk("ws_i", last_i, LP3);
    chk("ws_q", last_q, LP3);

    // write in DONE begins new frame
    chk("dn_complete", complete, 1);
    write_word(4'h6);
    chk("dn_complete_fall", complete, 0);
    chk("dn_level", level, 1);
    chk("dn_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    run_count(8);
    chk("dn_strobes", strobes, 1);
    chk("dn_i", last_i, LN1);
    chk("dn_q", last_q, LP3);

    // enable drop mid-frame
    to_load();
    for (int k = 1; k <= 5; k++) write_word(4'(k));
    start = 1'b1; tick(); start = 1'b0;
    run_count(2 * SYM_DIV);
    chk("en_strobes", strobes, 2);
    chk("en_i", last_i, LN3);
    chk("en_q", last_q, LP3);
    enable = 1'b0; tick();
    chk("en_busy", busy, 0);
    chk("en_complete", complete, 0);
    chk("en_level", level, 0);
    chk("en_sym_i", sym_i, 0);
    chk("en_sym_q", sym_q, 0);
    run_count(12);
    chk("en_no_strobes", strobes, 0);

    // async reset mid-frame
    enable = 1'b1; tick();
    write_word(4'h3); write_word(4'hC);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("ar_busy_pre", busy, 1);
    reset = 1'b0; #1;
    chk("ar_busy", busy, 0);
    chk("ar_level", level, 0);
    #2 reset = 1'b1;
    run_count(12);
    chk("ar_no_strobes", strobes, 0);
    chk("ar_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qam_mapper_controller.md
# qam_mapper_controller

Transmit-side counterpart of the hard-decision demapper controller. The host loads a frame of 4-bit 16-QAM symbol words into an internal buffer on `dclk`, then issues a start. The block then replays the frame one symbol every `SYM_DIV` clocks as Gray-mapped signed I/Q levels for the modulator. It signals completion back to the host.

## Interface
- `DEPTH`, 16: frame buffer capacity in symbols (≥2).
- `SYM_DIV`, 4: `dclk` cycles per output symbol (≥2).
- `dclk`  in  1  single clock for the whole block; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable`  in  1  block enable; low forces IDLE and empties the buffer.
- `wr_en`  in  1  host write strobe; one word per cycle.
- `wr_data`  in  4  symbol word: [3:2] = I bits, [1:0] = Q bits.
- `start`  in  1  host request to transmit the loaded frame.
- `level`  out  $clog2(DEPTH+1)  number of words currently loaded.
- `full`  out  1  `level == DEPTH`.
- `overrun`  out  1  sticky: a write was dropped; cleared on entry to IDLE.
- `busy`  out  1  high while in SEND.
- `complete`  out  1  high while in DONE.
- `sym_valid`  out  1  one-cycle strobe marking a new symbol on `sym_i`/`sym_q`.
- `sym_i`, `sym_q`  out  3 each  signed two's-complement levels in {-3, -1, +1, +3}.

## Operation
- Reset values: state IDLE; `level`=0; `full`, `overrun`, `busy`, `complete`, `sym_valid` = 0; `sym_i`=`sym_q`=3'b000. The divider and read pointer are 0.
- Gray mapping is applied per 2-bit field: 00→-3 (3'b101), 01→-1 (3'b111), 11→+1 (3'b001), 10→+3 (3'b011).
- IDLE (2'b00): writes and `start` are ignored. Moves to LOAD when `enable`=1.
- LOAD (2'b01):
  - A write with `level`<`DEPTH` stores the word and increments `level`.
  - A write with `full`=1 is dropped and sets `overrun`.
  - `start`=1 with `level`>0 moves the block to SEND. `start` with `level`=0 is ignored.
  - When `wr_en` and `start` are in the same cycle, the write is accepted first; SEND then includes that word.
- SEND (2'b10):
  - Writes are dropped and set `overrun`.
  - The divider counts 0..`SYM_DIV`-1. On the edge where it equals `SYM_DIV`-1, the block:
    - wraps the divider to 0,
    - registers the next buffered word, mapped, onto `sym_i`/`sym_q`,
    - pulses `sym_valid`,
    - advances the read pointer.
  - After the word at index `level`-1 is emitted, the block moves to DONE on that same edge.
- DONE (2'b11):
  - Read pointer and `level` are cleared. `overrun` is held.
  - A write is stored as word 0 (`level`=1), `complete` drops, and the block moves to LOAD.
  - `start` is ignored.
- `enable`=0 in any state: on the next edge the block goes to IDLE and restores the reset values of all outputs.
- `sym_i`/`sym_q` hold their last emitted value until IDLE.

## Timing
- Write latency: `level`/`full` update on the edge that samples `wr_en`.
- Start latency: `start` sampled at edge E0 → `busy`=1 after E0. The first `sym_valid` is high after edge E0+`SYM_DIV`. Later symbols follow every `SYM_DIV` edges.
- The last symbol's `sym_valid` cycle coincides with `complete`=1 and `busy`=0.
- Frame duration is N×`SYM_DIV` cycles from E0 to the last strobe, where N = `level` at start.
- Asynchronous reset takes effect immediately, mid-frame included. Transmission does not resume after reset release; the block starts in IDLE.

## Test plan
- Reset held low with random inputs → all outputs at reset values. After release with `enable`=0 → stays IDLE, `level`=0.
- Enable, write 0x0, 0x5, 0xF, then `start` at E0 (`SYM_DIV`=4) → `sym_valid` after E4/E8/E12 with (I,Q) = (-3,-3), (-1,-1), (+1,+1). `complete`=1 after E12.
- Write 17 words with `DEPTH`=16 → `full`=1 after the 16th write and `overrun`=1 after the 17th. Then `start` → exactly 16 strobes.
- `start` with `level`=0 → remains in LOAD, `busy`=0. Write 0xA and `start` in the same cycle → one symbol (+3,+3) emitted.
- Drop `enable` after the 2nd strobe of a 5-word frame → IDLE next edge, no further `sym_valid`, `level`=0, `sym_i`=`sym_q`=0.
- In DONE, write 0x6 → `complete` falls, LOAD with `level`=1. Then `start` → a single strobe with (-1,+3).
